gbuff_arbiter: RTL

Shares one single-port, write-first global buffer between two requesters. Requester 0 is the systolic-array datapath; requester 1 is the PS/loader. Each requester uses a valid/ready handshake, and the arbiter grants them round-robin. The arbiter drives the buffer's en/we/addr/wdata pins and routes the 1-cycle read data back to whichever requester issued the read. It sits between the requesters and one global_buffer instance (input, weight or output SRAM).

---
 rtl/gbuff_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gbuff_arbiter.sv
// gbuff_arbiter: round-robin arbiter sharing one single-port, write-first
// global buffer between the systolic datapath (requester 0) and the
// PS/loader (requester 1). Read data returns one cycle after acceptance and
// is steered to the requester that issued the read.
// Optional macro GBUFF_ARB_LOCK_EN adds a lock FSM that lets requester 1
// hold the buffer for a burst while req1_lock_i stays high.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module gbuff_arbiter #(
  parameter int AW = `ADDR_WIDTH,
  parameter int DW = `WORD_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic          req0_we_i,
  input  logic [AW-1:0] req0_addr_i,
  input  logic [DW-1:0] req0_wdata_i,
  output logic          rsp0_valid_o,
  output logic [DW-1:0] rsp0_rdata_o,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic          req1_we_i,
  input  logic [AW-1:0] req1_addr_i,
  input  logic [DW-1:0] req1_wdata_i,
  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp1_rdata_o,
  input  logic          req1_lock_i,
  output logic          gb_en_o,
  output logic          gb_we_o,
  output logic [AW-1:0] gb_addr_o,
  output logic [DW-1:0] gb_wdata_o,
  input  logic [DW-1:0] gb_rdata_i,
  output logic          busy_o
);

  logic last_grant;
  logic gnt0;
  logic gnt1;
  logic xfer;
  logic lock_act;
  logic rsp_pend_p1;
  logic rsp_id_p1;

`ifdef GBUFF_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t lock_state;
  lock_state_t lock_state_nxt;

  // Lock only holds while requester 1 keeps req1_lock_i high; dropping it
  // releases the buffer in the same cycle.
  assign lock_act = (lock_state == LOCKED) && req1_lock_i;

  // Lock state register
  always_ff @(posedge clk_i) begin
    if (rst_i) lock_state <= IDLE;
    else       lock_state <= lock_state_nxt;
  end

  // Lock next-state: enter on a locked req1 transfer, leave when lock drops
  always_comb begin
    lock_state_nxt = lock_state;
    case (lock_state)
      IDLE:    if (gnt1 && req1_lock_i) lock_state_nxt = LOCKED;
      LOCKED:  if (!req1_lock_i)        lock_state_nxt = IDLE;
      default: lock_state_nxt = IDLE;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = req1_lock_i;
  assign lock_act    = 1'b0;
`endif

  // Grant: round-robin on conflict, favouring the requester not served last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      if (lock_act) begin
        gnt1 = req1_valid_i;
      end else if (req0_valid_i && req1_valid_i) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid_i;
        gnt1 = req1_valid_i;
      end
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign xfer         = gnt0 | gnt1;

  // Buffer pins follow the granted requester; requester 0 fields when idle
  assign gb_en_o    = xfer;
  assign gb_we_o    = gnt1 ? req1_we_i : (gnt0 & req0_we_i);
  assign gb_addr_o  = gnt1 ? req1_addr_i  : req0_addr_i;
  assign gb_wdata_o = gnt1 ? req1_wdata_i : req0_wdata_i;

  // Remember who was served; reset value 1 lets requester 0 win first
  always_ff @(posedge clk_i) begin
    if (rst_i)     last_grant <= 1'b1;
    else if (xfer) last_grant <= gnt1;
  end

  // ---- stage p0 -> p1: read accepted, buffer data returns next cycle ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_pend_p1 <= 1'b0;
      rsp_id_p1   <= 1'b0;
    end else begin
      rsp_pend_p1 <= xfer && !gb_we_o;
      rsp_id_p1   <= xfer && !gb_we_o && gnt1;
    end
  end

  // A response pending when reset rises is dropped, not delivered.
  assign rsp0_valid_o = rsp_pend_p1 && !rsp_id_p1 && !rst_i;
  assign rsp1_valid_o = rsp_pend_p1 &&  rsp_id_p1 && !rst_i;
  assign rsp0_rdata_o = rsp0_valid_o ? gb_rdata_i : '0;
  assign rsp1_rdata_o = rsp1_valid_o ? gb_rdata_i : '0;
  assign busy_o       = rsp_pend_p1;

endmodule
